// File: rtl/maxpool2d.sv
// Sequential 2D max-pooling over a channel-major Q16.16 feature map, one window element per cycle.
// Optional fused ReLU on the stored maxima when MAXPOOL_RELU_EN is defined.
module maxpool2d #(
   parameter int IN_H   = 4,
   parameter int IN_W   = 4,
   parameter int CH     = 2,
   parameter int POOL_H = 2,
   parameter int POOL_W = 2,
   parameter int OUT_H  = IN_H / POOL_H,
   parameter int OUT_W  = IN_W / POOL_W,
   parameter int BITS   = 31
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  start,
   input  logic [IN_H*IN_W*CH*(BITS+1)-1:0]      data_in,
   output logic [OUT_H*OUT_W*CH*(BITS+1)-1:0]    data_out,
   output logic                                  done
);

   localparam int W    = BITS + 1;
   localparam int NIN  = IN_H * IN_W * CH;
   localparam int NOUT = OUT_H * OUT_W * CH;
   localparam int K    = POOL_H * POOL_W;
   localparam int CHW  = (CH > 1)    ? $clog2(CH)    : 1;
   localparam int OHW  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int OWW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int KW   = (K > 1)     ? $clog2(K)     : 1;
   localparam int IAW  = (NIN > 1)   ? $clog2(NIN)   : 1;
   localparam int OAW  = (NOUT > 1)  ? $clog2(NOUT)  : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [BITS:0] MOST_NEG = {1'b1, {BITS{1'b0}}};

   logic [1:0]            state_q, state_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic [OHW-1:0]        orow_q, orow_d;
   logic [OWW-1:0]        ocol_q, ocol_d;
   logic [KW-1:0]         k_q, k_d;
   logic signed [BITS:0]  max_q, max_d;
   logic                  done_q, done_d;
   logic [BITS:0]         dout_q [NOUT];

   logic signed [BITS:0]  din_s [NIN];
   logic signed [BITS:0]  elem_s;
   logic [BITS:0]         wval_s;
   logic [IAW-1:0]        addr_s;
   logic [OAW-1:0]        oidx_s;
   logic                  wr_en_s;

   genvar g;
   for (g = 0; g < NIN; g++) begin : g_unpack
      assign din_s[g] = data_in[g*W +: W];
   end
   for (g = 0; g < NOUT; g++) begin : g_pack
      assign data_out[g*W +: W] = dout_q[g];
   end

   assign done = done_q;

   // Window element address, output slot and the value committed on WRITE
   always_comb begin
      addr_s = IAW'(int'(ch_q) * IN_H * IN_W
                  + (int'(orow_q) * POOL_H + int'(k_q) / POOL_W) * IN_W
                  + int'(ocol_q) * POOL_W + int'(k_q) % POOL_W);
      oidx_s = OAW'(int'(ch_q) * OUT_H * OUT_W + int'(orow_q) * OUT_W + int'(ocol_q));
      elem_s = din_s[addr_s];
`ifdef MAXPOOL_RELU_EN
      wval_s = max_q[BITS] ? {W{1'b0}} : max_q;
`else
      wval_s = max_q;
`endif
   end

   // Next-state logic: scan a window, write its max, walk ocol -> orow -> ch
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      k_d     = k_q;
      max_d   = max_q;
      done_d  = done_q;
      wr_en_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SCAN;
               ch_d    = {CHW{1'b0}};
               orow_d  = {OHW{1'b0}};
               ocol_d  = {OWW{1'b0}};
               k_d     = {KW{1'b0}};
               max_d   = MOST_NEG;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (elem_s > max_q) begin
               max_d = elem_s;
            end else begin
               max_d = max_q;
            end
            if (k_q == KW'(K - 1)) begin
               state_d = S_WRITE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_WRITE: begin
            wr_en_s = 1'b1;
            max_d   = MOST_NEG;
            k_d     = {KW{1'b0}};
            state_d = S_SCAN;
            if (ocol_q == OWW'(OUT_W - 1)) begin
               ocol_d = {OWW{1'b0}};
               if (orow_q == OHW'(OUT_H - 1)) begin
                  orow_d = {OHW{1'b0}};
                  if (ch_q == CHW'(CH - 1)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     ch_d = ch_q + CHW'(1);
                  end
               end else begin
                  orow_d = orow_q + OHW'(1);
               end
            end else begin
               ocol_d = ocol_q + OWW'(1);
            end
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end else begin
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   // Control and datapath state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         ch_q    <= {CHW{1'b0}};
         orow_q  <= {OHW{1'b0}};
         ocol_q  <= {OWW{1'b0}};
         k_q     <= {KW{1'b0}};
         max_q   <= {W{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         k_q     <= k_d;
         max_q   <= max_d;
         done_q  <= done_d;
      end
   end

   // Output map; retained outside WRITE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NOUT; i++) begin
            dout_q[i] <= {W{1'b0}};
         end
      end else if (wr_en_s) begin
         dout_q[oidx_s] <= wval_s;
      end else begin
         dout_q[oidx_s] <= dout_q[oidx_s];
      end
   end

endmodule

// File: tb/tb_maxpool2d.sv
// Scoreboard bench for maxpool2d: a 4x4x2 instance and a 5x5x1 instance against a loop-based reference.
module tb_maxpool2d;
   typedef logic signed [31:0] word_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          start5 = 1'b0;
   logic [1023:0] data_in;
   logic [255:0]  data_out;
   logic          done;
   logic [799:0]  data_in5;
   logic [127:0]  data_out5;
   logic          done5;

   word_t din4 [32];
   word_t din5 [25];
   word_t dout4 [8];
   word_t dout5 [4];
   word_t src [32];
   word_t mdl [8];
   word_t last4 [8];
   word_t last5 [4];
   word_t exp4_q [$];
   word_t exp5_q [$];
   int    lat4_q [$];
   int    lat5_q [$];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic done_prev = 1'b0;
   logic done5_prev = 1'b0;

   maxpool2d u_dut (
      .clk(clk), .rstn(rstn), .start(start),
      .data_in(data_in), .data_out(data_out), .done(done)
   );

   maxpool2d #(.IN_H(5), .IN_W(5), .CH(1)) u_dut5 (
      .clk(clk), .rstn(rstn), .start(start5),
      .data_in(data_in5), .data_out(data_out5), .done(done5)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < 32; i++) data_in[i*32 +: 32] = din4[i];
   end
   always_comb begin
      for (int i = 0; i < 25; i++) data_in5[i*32 +: 32] = din5[i];
   end
   always_comb begin
      for (int i = 0; i < 8; i++) dout4[i] = data_out[i*32 +: 32];
   end
   always_comb begin
      for (int i = 0; i < 4; i++) dout5[i] = data_out5[i*32 +: 32];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: max over each non-overlapping 2x2 window, channel-major
   function automatic void model(input int ih, input int iw, input int nch);
      int oh, ow;
      word_t m, v;
      oh = ih / 2;
      ow = iw / 2;
      for (int c = 0; c < nch; c++)
         for (int orow = 0; orow < oh; orow++)
            for (int ocol = 0; ocol < ow; ocol++) begin
               m = 32'sh8000_0000;
               for (int pr = 0; pr < 2; pr++)
                  for (int pc = 0; pc < 2; pc++) begin
                     v = src[c*ih*iw + (orow*2 + pr)*iw + ocol*2 + pc];
                     if (v > m) m = v;
                  end
`ifdef MAXPOOL_RELU_EN
               if (m < 0) m = 32'sd0;
`endif
               mdl[c*oh*ow + orow*ow + ocol] = m;
            end
   endfunction

   // Monitor for the 4x4x2 instance: on done rising, pop and compare
   always @(negedge clk) begin : mon4
      word_t w;
      if (rstn && done && !done_prev) begin
         if (exp4_q.size() < 8 || lat4_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon4_unexpected_done actual=1 expected=0");
         end else begin
            check("done4_latency", cyc, lat4_q.pop_front());
            for (int i = 0; i < 8; i++) begin
               w = exp4_q.pop_front();
               check($sformatf("dout4[%0d]", i), dout4[i], w);
            end
         end
      end
      done_prev <= done;
   end

   // Monitor for the 5x5x1 instance
   always @(negedge clk) begin : mon5
      word_t w;
      if (rstn && done5 && !done5_prev) begin
         if (exp5_q.size() < 4 || lat5_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon5_unexpected_done actual=1 expected=0");
         end else begin
            check("done5_latency", cyc, lat5_q.pop_front());
            for (int i = 0; i < 4; i++) begin
               w = exp5_q.pop_front();
               check($sformatf("dout5[%0d]", i), dout5[i], w);
            end
         end
      end
      done5_prev <= done5;
   end

   // Called right after a negedge: next posedge is the first to sample start
   task automatic launch4(input word_t e [8]);
      for (int i = 0; i < 32; i++) din4[i] = src[i];
      for (int i = 0; i < 8; i++) begin
         exp4_q.push_back(e[i]);
         last4[i] = e[i];
      end
      lat4_q.push_back(cyc + 41);
      start = 1'b1;
   endtask

   task automatic launch5(input word_t e [4]);
      for (int i = 0; i < 25; i++) din5[i] = src[i];
      for (int i = 0; i < 4; i++) begin
         exp5_q.push_back(e[i]);
         last5[i] = e[i];
      end
      lat5_q.push_back(cyc + 21);
      start5 = 1'b1;
   endtask

   task automatic wait4();
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL timeout4 actual=done_low expected=done_high");
         exp4_q.delete();
         lat4_q.delete();
      end
   endtask

   task automatic wait5();
      int n = 0;
      while (!done5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done5) begin
         checks++;
         failures++;
         $display("FAIL timeout5 actual=done_low expected=done_high");
         exp5_q.delete();
         lat5_q.delete();
      end
   endtask

   // Drop start: done must fall on the next edge, outputs retained
   task automatic finish4();
      start = 1'b0;
      @(negedge clk);
      check("done4_drop", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) check("dout4_retain", dout4[i], last4[i]);
   endtask

   task automatic finish5();
      start5 = 1'b0;
      @(negedge clk);
      check("done5_drop", {31'd0, done5}, 32'd0);
      for (int i = 0; i < 4; i++) check("dout5_retain", dout5[i], last5[i]);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++) src[i] = $urandom;
   endtask

   initial begin
      word_t lit4 [8];
      word_t lit5 [4];
      word_t m5 [4];
      for (int i = 0; i < 32; i++) begin
         din4[i] = 32'sd0;
         src[i]  = 32'sd0;
      end
      for (int i = 0; i < 25; i++) din5[i] = 32'sd0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_done4", {31'd0, done}, 32'd0);
      check("rst_done5", {31'd0, done5}, 32'd0);
      for (int i = 0; i < 8; i++) check("rst_dout4", dout4[i], 32'd0);
      for (int i = 0; i < 4; i++) check("rst_dout5", dout5[i], 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Box-filter chain with literal expectations
      for (int i = 0; i < 32; i++)
         src[i] = (72 + 54*((i % 16) / 4) + 9*(i % 4) + 10*(i / 16)) * 65536;
      lit4 = '{135*65536, 153*65536, 243*65536, 261*65536,
               145*65536, 163*65536, 253*65536, 271*65536};
      launch4(lit4);
      wait4();
      finish4();

      // Negative window, ties and extremes, then random maps
      for (int run = 0; run < 4; run++) begin
         fill_random();
         if (run == 0) begin
            src[0]  = -5 * 65536;  src[1]  = -3 * 65536;
            src[4]  = -7 * 65536;  src[5]  = -1 * 65536;
            src[16] = 32'sh7FFF_FFFF; src[17] = 32'sh8000_0000;
            src[20] = 32'sh7FFF_FFFF; src[21] = 32'sd0;
            src[10] = 32'sh8000_0000; src[11] = 32'sh8000_0000;
            src[14] = 32'sh8000_0000; src[15] = 32'sh8000_0000;
         end
         model(4, 4, 2);
         launch4(mdl);
         wait4();
         finish4();
      end

      // Asynchronous reset mid-operation, then rerun with start held high
      fill_random();
      model(4, 4, 2);
      launch4(mdl);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check("midrst_done4", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) check("midrst_dout4", dout4[i], 32'd0);
      exp4_q.delete();
      lat4_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      launch4(mdl);
      wait4();
      finish4();

      // start glitches low during SCAN; result and latency unchanged
      fill_random();
      model(4, 4, 2);
      launch4(mdl);
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      wait4();
      finish4();
      fill_random();
      model(4, 4, 2);
      launch4(mdl);
      wait4();
      finish4();

      // 5x5 map: trailing row/col never read
      for (int i = 0; i < 25; i++)
         src[i] = ((i / 5 == 4) || (i % 5 == 4)) ? 1000 * 65536 : (i + 1) * 65536;
      lit5 = '{7*65536, 9*65536, 17*65536, 19*65536};
      launch5(lit5);
      wait5();
      finish5();
      fill_random();
      model(5, 5, 1);
      for (int i = 0; i < 4; i++) m5[i] = mdl[i];
      launch5(m5);
      wait5();
      finish5();

      repeat (2) @(negedge clk);
      if (exp4_q.size() != 0 || exp5_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", exp4_q.size() + exp5_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
